// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// State encodings, default parameters and packed control-row constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  localparam int INIT_CYCLES_D  = 4;
  localparam int WAIT_TIMEOUT_D = 255;
  localparam int CNT_W_D        = 16;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t C_INIT   = 8'b0111_1111;
  localparam ctrl_t C_RUN    = 8'b1101_0110;
  localparam ctrl_t C_HZ     = 8'b0001_1110;
  localparam ctrl_t C_BR     = 8'b1111_0110;
  localparam ctrl_t C_FREEZE = 8'b0000_0011;
  localparam ctrl_t C_NONE   = 8'b0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async low), inc, q[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (inc && !(&r_q))
      r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: turns hazard, branch and dmem wait into
// per-register enable/bubble/flush, plus init, timeout, halt, counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES  = INIT_CYCLES_D,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_D,
  parameter int CNT_W        = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_init_cnt;
  logic [3:0] w_init_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;
  logic       r_err;
  logic       w_err_set;
  ctrl_t      w_ctrl;
  logic       w_flush_inc;
  logic       w_stall_inc;

  // One-hot RUN priority decode
  logic w_halt;
  logic w_frz;
  logic w_hz;
  logic w_br;
  logic w_idle;

  assign w_halt = halt_req;
  assign w_frz  = !w_halt && dmem_req && !dmem_ready;
  assign w_hz   = !w_halt && !w_frz && hz_stall;
  assign w_br   = !w_halt && !w_frz && !hz_stall
                  && branch_taken;
  assign w_idle = !w_halt && !w_frz && !w_hz && !w_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= w_init_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ctrl      = C_NONE;
    w_init_nxt  = r_init_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_err_set   = 1'b0;
    w_flush_inc = 1'b0;
    unique case (r_state)
      S_INIT: begin
        w_ctrl = C_INIT;
        if (r_init_cnt == 4'(INIT_CYCLES - 1)) begin
          w_next     = S_RUN;
          w_init_nxt = '0;
        end else begin
          w_init_nxt = r_init_cnt + 4'd1;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          w_halt: begin
            w_ctrl = C_NONE;
            w_next = S_HALT;
          end
          w_frz: begin
            w_ctrl     = C_FREEZE;
            w_next     = S_MEM_WAIT;
            w_wait_nxt = 8'd1;
          end
          w_hz: w_ctrl = C_HZ;
          w_br: begin
            w_ctrl      = C_BR;
            w_flush_inc = 1'b1;
          end
          w_idle: w_ctrl = C_RUN;
          default: w_ctrl = C_NONE;
        endcase
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          w_ctrl     = C_RUN;
          w_next     = S_RUN;
          w_wait_nxt = '0;
        end else begin
          w_ctrl = C_FREEZE;
          if (r_wait_cnt >= 8'(WAIT_TIMEOUT)) begin
            w_err_set = 1'b1;
            w_next    = S_HALT;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end
      end
      S_HALT: w_ctrl = C_NONE;
      default: w_next = S_INIT;
    endcase
  end

  // Halt entry freezes the PC but is not a stall
  assign w_stall_inc = !w_ctrl.pc_en &&
    ((r_state == S_RUN && !halt_req) ||
     r_state == S_MEM_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .q     (flush_count)
  );

  assign pc_en        = w_ctrl.pc_en;
  assign ifid_en      = w_ctrl.ifid_en;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_en      = w_ctrl.idex_en;
  assign idex_bubble  = w_ctrl.idex_bubble;
  assign exmem_en     = w_ctrl.exmem_en;
  assign memwb_en     = w_ctrl.memwb_en;
  assign memwb_bubble = w_ctrl.memwb_bubble;
  assign state        = r_state;
  assign err_timeout  = r_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, corner sequences and
// random stimulus against a behavioural model.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int INIT = 4;
  localparam int TO   = 5;
  localparam int W    = 16;
  localparam int SAT  = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz_stall = 0, branch_taken = 0;
  logic dmem_req = 0, dmem_ready = 0, halt_req = 0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic exmem_en, memwb_en, memwb_bubble;
  logic [1:0] state;
  logic err_timeout;
  logic [W-1:0] stall_cycles, flush_count;
  logic [7:0] outv;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INIT_CYCLES(INIT), .WAIT_TIMEOUT(TO), .CNT_W(W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hz_stall(hz_stall), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .memwb_bubble(memwb_bubble), .state(state),
    .err_timeout(err_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // {pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb, memwb_bubble}
  assign outv = {pc_en, ifid_en, ifid_flush, idex_en,
                 idex_bubble, exmem_en, memwb_en, memwb_bubble};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: spec state numbers, plain integers
  int m_state, m_init_left, m_mw, m_err, m_stall, m_flush;

  task automatic m_reset();
    m_state = 0; m_init_left = INIT; m_mw = 0;
    m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [7:0] m_out(logic hz, logic br,
    logic req, logic rdy, logic halt);
    logic [7:0] run_all, freeze;
    run_all = 8'b1101_0110;
    freeze  = 8'b0000_0011;
    case (m_state)
      0: return 8'b0111_1111;
      1: begin
        if (halt) return 8'h00;
        if (req && !rdy) return freeze;
        if (hz) return 8'b0001_1110;
        if (br) return 8'b1111_0110;
        return run_all;
      end
      2: return rdy ? run_all : freeze;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int bump(int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic m_step(logic hz, logic br, logic req,
                        logic rdy, logic halt);
    case (m_state)
      0: begin
        m_init_left--;
        if (m_init_left == 0) m_state = 1;
      end
      1: begin
        if (halt) m_state = 3;
        else if (req && !rdy) begin
          m_state = 2; m_mw = 0; m_stall = bump(m_stall);
        end
        else if (hz) m_stall = bump(m_stall);
        else if (br) m_flush = bump(m_flush);
      end
      2: begin
        if (rdy) m_state = 1;
        else begin
          m_stall = bump(m_stall);
          m_mw++;
          if (m_mw == TO) begin
            m_err = 1; m_state = 3;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic cyc(logic hz, logic br, logic req,
    logic rdy, logic halt, bit use_tab = 0,
    logic [7:0] tab = 8'h00);
    hz_stall = hz; branch_taken = br; dmem_req = req;
    dmem_ready = rdy; halt_req = halt;
    #1;
    chk("ctrl", 32'(outv), 32'(m_out(hz, br, req, rdy, halt)));
    if (use_tab) chk("table", 32'(outv), 32'(tab));
    chk("state", 32'(state), 32'(m_state));
    chk("err", 32'(err_timeout), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    @(posedge clk);
    m_step(hz, br, req, rdy, halt);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse, asserted between edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    hz_stall = 0; branch_taken = 0; dmem_req = 0;
    dmem_ready = 0; halt_req = 0;
    #1;
    m_reset();
    chk("rst_state", 32'(state), 0);
    chk("rst_ctrl", 32'(outv), 32'h7f);
    chk("rst_err", 32'(err_timeout), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic to_run();
    do_reset();
    for (int i = 0; i < INIT; i++) cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic hz, br, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[7];
  int s0;

  initial begin
    vt[0] = '{0, 0, 0, 0, 8'b1101_0110};
    vt[1] = '{1, 0, 0, 0, 8'b0001_1110};
    vt[2] = '{1, 1, 0, 0, 8'b0001_1110};
    vt[3] = '{0, 1, 0, 0, 8'b1111_0110};
    vt[4] = '{0, 0, 1, 1, 8'b1101_0110};
    vt[5] = '{1, 0, 1, 1, 8'b0001_1110};
    vt[6] = '{0, 1, 1, 1, 8'b1111_0110};

    m_reset();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < INIT; i++) begin
      cyc(0, 0, 0, 0, 0);
    end
    #1;
    chk("first_pc_en", 32'(pc_en), 1);
    chk("run_state", 32'(state), 1);

    // RUN decode table
    for (int i = 0; i < 7; i++)
      cyc(vt[i].hz, vt[i].br, vt[i].req, vt[i].rdy,
          0, 1, vt[i].exp);
    chk("hz_br_stall", 32'(stall_cycles), 3);
    chk("hz_br_flush", 32'(flush_count), 2);

    // Memory access with ready latency 3
    s0 = int'(stall_cycles);
    cyc(0, 0, 1, 0, 0, 1, 8'b0000_0011);
    cyc(0, 0, 1, 0, 0, 1, 8'b0000_0011);
    cyc(0, 0, 1, 0, 0, 1, 8'b0000_0011);
    cyc(1, 1, 1, 1, 0, 1, 8'b1101_0110);
    #1;
    chk("mem_stall", 32'(stall_cycles), 32'(s0 + 3));
    chk("mem_back_run", 32'(state), 1);

    // Timeout: entry cycle plus TO wait cycles
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < TO; i++)
      cyc(0, 0, 1, 0, 0, 1, 8'b0000_0011);
    #1;
    chk("to_state", 32'(state), 3);
    chk("to_err", 32'(err_timeout), 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 1, 1, 1, 1, 8'h00);
    do_reset();

    // Reset in the middle of a memory wait
    for (int i = 0; i < INIT; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    do_reset();

    // Halt request
    for (int i = 0; i < INIT; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 1, 8'h00);
    cyc(0, 0, 0, 0, 0, 1, 8'h00);
    #1;
    chk("halt_state", 32'(state), 3);
    chk("halt_no_stall", 32'(stall_cycles), 0);

    // Randomised run against the model
    to_run();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 3) == 0,
          ($urandom % 3) == 0, ($urandom % 10) < 4,
          ($urandom % 64) == 0);
      if ((m_state == 3 && ($urandom % 4) == 0) ||
          ($urandom % 300) == 0)
        do_reset();
    end

    // Flush counter saturation
    to_run();
    branch_taken = 1'b1;
    repeat (SAT - 1) @(posedge clk);
    @(negedge clk); #1;
    chk("flush_near_sat", 32'(flush_count), 32'(SAT - 1));
    repeat (70000 - SAT + 1) @(posedge clk);
    @(negedge clk); #1;
    chk("flush_sat", 32'(flush_count), 32'(SAT));
    chk("flush_sat_stall", 32'(stall_cycles), 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
